// File: rtl/regfile_sb.sv
// Multi-port integer register file with a pending-write scoreboard for RAW stall detection.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic                any_busy
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;

    logic [NREGS-1:0] w_wr_en;
    logic [XLEN-1:0]  w_wr_data [NREGS];
    logic [NREGS-1:0] w_set;
    logic [AW-1:0]    w_ra [NRD];

    // Per-register write resolution; port 0 is scanned last so it overrides older stages.
    always_comb begin
        w_wr_en = '0;
        w_set   = '0;
        for (int r = 0; r < NREGS; r++) begin
            w_wr_data[r] = '0;
        end
        for (int r = 1; r < NREGS; r++) begin
            for (int p = NWR - 1; p >= 0; p--) begin
                if (wen[p] && (waddr[p*AW +: AW] == AW'(r))) begin
                    w_wr_en[r]   = 1'b1;
                    w_wr_data[r] = wdata[p*XLEN +: XLEN];
                end
            end
            w_set[r] = issue_valid && (issue_rd == AW'(r));
        end
    end

    // Entry 0 never sees an enable or a set, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (w_wr_en[r]) begin
                    r_regs[r] <= w_wr_data[r];
                end
                r_busy[r] <= w_set[r] | (r_busy[r] & ~w_wr_en[r]);
            end
        end
    end

    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            w_ra[i] = raddr[i*AW +: AW];
            if (w_ra[i] != '0) begin
                rdata[i*XLEN +: XLEN] = r_regs[w_ra[i]];
                rbusy[i]              = r_busy[w_ra[i]];
`ifdef RF_BYPASS_EN
                // A retiring write satisfies the reader unless a newer producer issues now.
                if (w_wr_en[w_ra[i]]) begin
                    rdata[i*XLEN +: XLEN] = w_wr_data[w_ra[i]];
                    if (!w_set[w_ra[i]]) begin
                        rbusy[i] = 1'b0;
                    end
                end
`endif
            end
        end
    end

    assign any_busy = |r_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, corner sequences and
// randomized traffic against an array-based reference model.
module tb_regfile_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic [NWR-1:0]      wen;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic                any_busy;

    int n_chk  = 0;
    int n_pass = 0;

    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .wen(wen), .waddr(waddr), .wdata(wdata), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .any_busy(any_busy)
    );

    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  ra0, ra1;
        logic [31:0] e0, e1;
        logic [1:0]  eb;
        logic        ea;
    } vec_t;

    vec_t vt[17];

    function automatic vec_t mk(logic [1:0] w, logic [4:0] a0, logic [31:0] d0,
                                logic [4:0] a1, logic [31:0] d1, logic iv, logic [4:0] ird,
                                logic [4:0] r0, logic [4:0] r1, logic [31:0] e0,
                                logic [31:0] e1, logic [1:0] eb, logic ea);
        vec_t v;
        v.wen = w; v.wa0 = a0; v.wd0 = d0; v.wa1 = a1; v.wd1 = d1;
        v.iv = iv; v.ird = ird; v.ra0 = r0; v.ra1 = r1;
        v.e0 = e0; v.e1 = e1; v.eb = eb; v.ea = ea;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic [1:0] w, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1, input logic iv,
                         input logic [4:0] ird, input logic [4:0] r0, input logic [4:0] r1);
        wen = w;
        waddr = {a1, a0};
        wdata = {d1, d0};
        issue_valid = iv;
        issue_rd = ird;
        raddr = {r1, r0};
    endtask

    task automatic model_clear();
        for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Lowest-index port wins data; any enabled write retires; a new issue is younger.
    task automatic model_commit();
        bit taken [NREGS];
        int a;
        for (int r = 0; r < NREGS; r++) taken[r] = 1'b0;
        for (int p = 0; p < NWR; p++) begin
            a = int'(waddr[p*AW +: AW]);
            if (wen[p] && a != 0) begin
                if (!taken[a]) m_regs[a] = wdata[p*XLEN +: XLEN];
                taken[a] = 1'b1;
                m_busy[a] = 1'b0;
            end
        end
        if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    endtask

    function automatic logic [31:0] exp_rd(input int a);
        if (a == 0) return '0;
`ifdef RF_BYPASS_EN
        for (int p = 0; p < NWR; p++)
            if (wen[p] && int'(waddr[p*AW +: AW]) == a) return wdata[p*XLEN +: XLEN];
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_bz(input int a);
        if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
        for (int p = 0; p < NWR; p++)
            if (wen[p] && int'(waddr[p*AW +: AW]) == a && !(issue_valid && int'(issue_rd) == a))
                return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic logic model_any();
        logic b = 1'b0;
        for (int r = 0; r < NREGS; r++) b |= m_busy[r];
        return b;
    endfunction

    initial begin
        vt[0]  = mk(2'b00, 0, 0,            0, 0,            0, 0, 0, 31, 0,            0,            2'b00, 0);
        vt[1]  = mk(2'b10, 0, 0,            5, 32'hDEADBEEF, 0, 0, 1, 2,  0,            0,            2'b00, 0);
        vt[2]  = mk(2'b01, 0, 32'h1234,     0, 0,            0, 0, 5, 0,  32'hDEADBEEF, 0,            2'b00, 0);
        vt[3]  = mk(2'b11, 7, 32'hAAAA0000, 7, 32'h5555FFFF, 0, 0, 0, 5,  0,            32'hDEADBEEF, 2'b00, 0);
        vt[4]  = mk(2'b00, 0, 0,            0, 0,            0, 0, 7, 0,  32'hAAAA0000, 0,            2'b00, 0);
        vt[5]  = mk(2'b00, 0, 0,            0, 0,            1, 9, 9, 7,  0,            32'hAAAA0000, 2'b00, 0);
        vt[6]  = mk(2'b00, 0, 0,            0, 0,            0, 0, 9, 9,  0,            0,            2'b11, 1);
        vt[7]  = mk(2'b10, 0, 0,            9, 32'h42,       0, 0, 7, 5,  32'hAAAA0000, 32'hDEADBEEF, 2'b00, 1);
        vt[8]  = mk(2'b00, 0, 0,            0, 0,            0, 0, 9, 0,  32'h42,       0,            2'b00, 0);
        vt[9]  = mk(2'b01, 9, 32'h55,       0, 0,            1, 9, 5, 7,  32'hDEADBEEF, 32'hAAAA0000, 2'b00, 0);
        vt[10] = mk(2'b00, 0, 0,            0, 0,            0, 0, 9, 9,  32'h55,       32'h55,       2'b11, 1);
        vt[11] = mk(2'b00, 0, 0,            0, 0,            1, 9, 9, 2,  32'h55,       0,            2'b01, 1);
        vt[12] = mk(2'b00, 0, 0,            0, 0,            0, 0, 9, 0,  32'h55,       0,            2'b01, 1);
        vt[13] = mk(2'b10, 0, 0,            9, 32'h66,       0, 0, 7, 7,  32'hAAAA0000, 32'hAAAA0000, 2'b00, 1);
        vt[14] = mk(2'b00, 0, 0,            0, 0,            0, 0, 9, 5,  32'h66,       32'hDEADBEEF, 2'b00, 0);
        vt[15] = mk(2'b11, 3, 32'h11,       4, 32'h22,       0, 0, 9, 9,  32'h66,       32'h66,       2'b00, 0);
        vt[16] = mk(2'b00, 0, 0,            0, 0,            0, 0, 3, 4,  32'h11,       32'h22,       2'b00, 0);

        reset = 1'b1;
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0);
        model_clear();
        #12 reset = 1'b0;
        @(posedge clk); #1;

        for (int a = 0; a < NREGS; a++) begin
            raddr = {AW'(a), AW'(a)};
            #1;
            chk("reset_rdata0", rdata[31:0], 32'h0);
            chk("reset_rdata1", rdata[63:32], 32'h0);
            chk("reset_rbusy", {30'd0, rbusy}, 32'h0);
            chk("reset_any_busy", {31'd0, any_busy}, 32'h0);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) begin
            drive(vt[i].wen, vt[i].wa0, vt[i].wd0, vt[i].wa1, vt[i].wd1,
                  vt[i].iv, vt[i].ird, vt[i].ra0, vt[i].ra1);
            @(negedge clk);
            chk($sformatf("vec%0d_rdata0", i), rdata[31:0], vt[i].e0);
            chk($sformatf("vec%0d_rdata1", i), rdata[63:32], vt[i].e1);
            chk($sformatf("vec%0d_rbusy0", i), {31'd0, rbusy[0]}, {31'd0, vt[i].eb[0]});
            chk($sformatf("vec%0d_rbusy1", i), {31'd0, rbusy[1]}, {31'd0, vt[i].eb[1]});
            chk($sformatf("vec%0d_any_busy", i), {31'd0, any_busy}, {31'd0, vt[i].ea});
            model_commit();
            @(posedge clk); #1;
        end

        // Same-cycle write and read of x3 (x3 holds 0x11 here).
        drive(2'b10, 0, 0, 3, 32'h77, 1'b0, 0, 0, 3);
        @(negedge clk);
`ifdef RF_BYPASS_EN
        chk("bypass_rdata1", rdata[63:32], 32'h77);
`else
        chk("bypass_rdata1", rdata[63:32], 32'h11);
`endif
        chk("bypass_rbusy1", {31'd0, rbusy[1]}, 32'h0);
        model_commit();
        @(posedge clk); #1;
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 3);
        @(negedge clk);
        chk("after_bypass_rdata1", rdata[63:32], 32'h77);
        model_commit();
        @(posedge clk); #1;

        // Asynchronous reset between clock edges.
        drive(2'b01, 6, 32'h99, 0, 0, 1'b1, 4, 4, 6);
        @(negedge clk);
        model_commit();
        @(posedge clk); #1;
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 4, 6);
        #1;
        chk("pre_reset_rbusy0", {31'd0, rbusy[0]}, 32'h1);
        chk("pre_reset_rdata1", rdata[63:32], 32'h99);
        chk("pre_reset_any_busy", {31'd0, any_busy}, 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_rbusy0", {31'd0, rbusy[0]}, 32'h0);
        chk("async_reset_rdata1", rdata[63:32], 32'h0);
        chk("async_reset_any_busy", {31'd0, any_busy}, 32'h0);
        reset = 1'b0;
        model_clear();
        @(posedge clk); #1;

        for (int n = 0; n < 400; n++) begin
            logic [4:0] a0, a1, ir, r0, r1;
            a0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            ir = 5'($urandom_range(0, 7));
            r0 = 5'($urandom_range(0, 7));
            r1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            drive(2'($urandom_range(0, 3)), a0, $urandom, a1, $urandom,
                  1'($urandom_range(0, 1)), ir, r0, r1);
            @(negedge clk);
            for (int i = 0; i < NRD; i++) begin
                int ra;
                ra = int'(raddr[i*AW +: AW]);
                chk($sformatf("rand%0d_rdata%0d", n, i), rdata[i*XLEN +: XLEN], exp_rd(ra));
                chk($sformatf("rand%0d_rbusy%0d", n, i), {31'd0, rbusy[i]}, {31'd0, exp_bz(ra)});
            end
            chk($sformatf("rand%0d_any_busy", n), {31'd0, any_busy}, {31'd0, model_any()});
            model_commit();
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-port integer register file with an integrated pending-write scoreboard. Successor to the fixed 2R/2W core register file.
- Sits in the Decode stage. Serves NRD combinational read ports and accepts NWR prioritised write ports from later stages.
- Tracks which architectural registers have an issued-but-unretired write. Decode uses this to stall on RAW hazards.

Parameters:
- XLEN, 32, register data width in bits.
- NREGS, 32, number of architectural registers (power of two, >= 2). Register 0 is hard-wired to zero.
- NRD, 2, number of read ports (>= 1).
- NWR, 2, number of write ports (>= 1). Port 0 is the youngest pipeline stage and has the highest priority.
- AW, $clog2(NREGS), address width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- raddr  in  NRD*AW  read addresses; slice i belongs to read port i
- rdata  out  NRD*XLEN  read data per port
- rbusy  out  NRD  1 = the addressed register has a pending write
- wen  in  NWR  write enable per write port
- waddr  in  NWR*AW  write address per write port
- wdata  in  NWR*XLEN  write data per write port
- issue_valid  in  1  an instruction with a destination register is issued this cycle
- issue_rd  in  AW  destination register of the issued instruction
- any_busy  out  1  OR of all scoreboard bits; used by fence/CSR drain logic

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (reset).
- Reset state: all registers 1..NREGS-1 = 0; all scoreboard bits = 0; any_busy = 0.
- Outputs after reset: rdata reads 0 for every address; rbusy = 0.
- Reads:
  - Combinational, zero latency: rdata[i] = reg[raddr[i]].
  - Reads of address 0 always return 0 with rbusy = 0.
- Writes:
  - Registers update on the rising clk edge.
  - A write to address 0 is ignored.
  - When several enabled ports target the same nonzero address, the lowest-index port wins. Other ports write independently.
- Scoreboard, per register r (r != 0), evaluated at each rising edge:
  - set = issue_valid && issue_rd == r
  - clr = any enabled write port with waddr == r
  - set && clr: busy[r] <= 1. The new issue is younger than the retiring write.
  - set only: busy[r] <= 1.
  - clr only: busy[r] <= 0.
  - neither: busy[r] holds.
- Scoreboard edge cases:
  - issue_rd == 0 is ignored; busy[0] is constant 0.
  - Re-issue to an already-busy register keeps it busy. No counting is done: the scoreboard is single-outstanding per register, and the pipeline guarantees in-order writeback.
  - A write to a non-busy register is legal (e.g. a load-forwarded result). It updates the data; busy stays 0.
- rbusy and any_busy reflect the registered scoreboard state (current cycle), unless RF_BYPASS_EN is defined (see Optional Feature).
- Reset mid-operation: asserting reset clears data and scoreboard immediately, independent of clk. Writes and issues in that cycle are discarded.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - Each read port forwards same-cycle write data. rdata[i] = wdata of the highest-priority enabled port with waddr == raddr[i] (raddr != 0); otherwise the stored value.
  - rbusy[i] is forced to 0 when such a matching write exists and no same-cycle issue targets that register.
  - Adds one combinational priority mux per read port.
- Undefined:
  - A write becomes visible one cycle after its edge.
  - rbusy reflects only the registered busy bits. Decode stalls one extra cycle on back-to-back dependencies.

Test Plan:
- Reset then read all: pulse reset, read addresses 0..31 on every port -> rdata = 0x00000000, rbusy = 0, any_busy = 0.
- Basic write/read: wen[1], waddr[1]=5, wdata[1]=0xDEADBEEF; next cycle raddr[0]=5 -> rdata[0]=0xDEADBEEF. A write of 0x1234 to x0 -> a read of x0 returns 0.
- Write contention: wen=2'b11, both ports waddr=7, wdata[0]=0xAAAA0000, wdata[1]=0x5555FFFF -> x7 = 0xAAAA0000.
- Scoreboard lifecycle:
  - Step 1: issue_rd=9, issue_valid=1 -> rbusy=1 for raddr=9, any_busy=1.
  - Step 2: write x9 (value 0x42) -> busy clears next cycle.
  - Step 3: simultaneous issue_rd=9 plus write x9 -> stays busy.
- Bypass:
  - With RF_BYPASS_EN: same-cycle write x3=0x77 and raddr[1]=3 -> rdata[1]=0x77, rbusy[1]=0.
  - Without RF_BYPASS_EN: same stimulus -> rdata[1] = old x3 value.
- Async reset mid-operation: issue x4 and write x6=0x99, then assert reset between clock edges -> x6 = 0 and busy[4] = 0 immediately, with no clk edge required.
